// File: rtl/cpu_debug_ctrl.sv
// Run-control for the CPU core: handles RUN/HALT/STEP/CLEAR commands and drives the CPU halt input.
// It also counts retired instructions and records why the core last stopped.
module cpu_debug_ctrl #(
   parameter int STEP_W       = 8,
   parameter int CNT_W        = 32,
   parameter bit RESET_HALTED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_cmd_valid,
   output logic              dbg_cmd_ready,
   input  logic [1:0]        dbg_cmd,
   input  logic [STEP_W-1:0] step_count,
   input  logic              breakpoint_fired,
   input  logic              instruction_retired,
   output logic              halt,
   output logic [1:0]        dbg_state,
   output logic [1:0]        halt_cause,
   output logic              halted_on_bp,
   output logic              dbg_event,
   output logic [CNT_W-1:0]  retired_count
);

   // state    | meaning
   // HALTED   | CPU frozen, commands accepted
   // RUNNING  | CPU free-running until HALT cmd or breakpoint
   // STEPPING | CPU runs until remaining retirements done or breakpoint
   typedef enum logic [1:0] {
      ST_HALTED   = 2'b00,
      ST_RUNNING  = 2'b01,
      ST_STEPPING = 2'b10
   } state_e;

   localparam logic [1:0] CMD_RUN   = 2'b00;
   localparam logic [1:0] CMD_HALT  = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   localparam logic [1:0] CAUSE_RESET = 2'b00;
   localparam logic [1:0] CAUSE_CMD   = 2'b01;
   localparam logic [1:0] CAUSE_BP    = 2'b10;
   localparam logic [1:0] CAUSE_STEP  = 2'b11;

   localparam state_e RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUNNING;

   state_e            state_q, state_d;
   logic [1:0]        cause_q, cause_d;
   logic              sticky_q, sticky_d;
   logic              event_q, event_d;
   logic              mask_q, mask_d;
   logic [STEP_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic cmd_acc, ret, bp, clear;

   assign halt          = (state_q == ST_HALTED);
   assign dbg_cmd_ready = (state_q != ST_STEPPING);
   assign dbg_state     = state_q;
   assign halt_cause    = cause_q;
   assign halted_on_bp  = sticky_q;
   assign dbg_event     = event_q;
   assign retired_count = cnt_q;

   assign cmd_acc = dbg_cmd_valid && dbg_cmd_ready;
   assign ret     = instruction_retired && !halt;
   // The breakpoint flag is still high from the previous stop during the first cycle after resume.
   assign bp      = breakpoint_fired && !halt && !mask_q;

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      sticky_d = sticky_q;
      remain_d = remain_q;
      clear    = 1'b0;
      unique case (state_q)
         ST_HALTED: begin
            if (cmd_acc) begin
               unique case (dbg_cmd)
                  CMD_RUN:  state_d = ST_RUNNING;
                  CMD_STEP: begin
                     state_d  = ST_STEPPING;
                     remain_d = (step_count == '0) ? STEP_W'(1) : step_count;
                  end
                  CMD_CLEAR: begin
                     clear    = 1'b1;
                     sticky_d = 1'b0;
                     cause_d  = CAUSE_RESET;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUNNING: begin
            if (cmd_acc && dbg_cmd == CMD_CLEAR) begin
               clear    = 1'b1;
               sticky_d = 1'b0;
            end
            if (bp) begin
               state_d  = ST_HALTED;
               cause_d  = CAUSE_BP;
               sticky_d = 1'b1;
            end else if (cmd_acc && dbg_cmd == CMD_HALT) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_CMD;
            end
         end
         ST_STEPPING: begin
            if (bp) begin
               state_d  = ST_HALTED;
               cause_d  = CAUSE_BP;
               sticky_d = 1'b1;
            end else if (ret) begin
               remain_d = remain_q - STEP_W'(1);
               if (remain_q == STEP_W'(1)) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_STEP;
               end
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (ret && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign event_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
   assign mask_d  = halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RESET_STATE;
         cause_q  <= CAUSE_RESET;
         sticky_q <= 1'b0;
         event_q  <= 1'b0;
         mask_q   <= 1'b1;
         remain_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         sticky_q <= sticky_d;
         event_q  <= event_d;
         mask_q   <= mask_d;
         remain_q <= remain_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
